// File: rtl/eq_band_gain_mixer_pkg.sv
// Shared types and constants for the band-gain mixer: bus widths, gain format,
// the mixer FSM encoding and the output saturation helper.
package eq_pkg;

    localparam int NUM_BANDS      = 10;
    localparam int DATA_W         = 24;
    localparam int GAIN_W         = 12;
    localparam int ACC_W          = 41;
    localparam int IDX_W          = 4;
    localparam int GAIN_FRAC_BITS = 10;

    localparam logic [GAIN_W-1:0]       UNITY_GAIN = 12'h400;
    localparam logic [IDX_W-1:0]        BAND_COUNT = 4'd10;
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = 41'sd512;
    localparam logic signed [ACC_W-1:0] SAT_MAX    = 41'sd8388607;
    localparam logic signed [ACC_W-1:0] SAT_MIN    = -41'sd8388608;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } eq_state_t;

    // Clamp a wide signed value into the signed DATA_W output range.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] val);
        logic signed [DATA_W-1:0] res;
        if (val > SAT_MAX) begin
            res = 24'sh7FFFFF;
        end else if (val < SAT_MIN) begin
            res = 24'sh800000;
        end else begin
            res = val[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/eq_band_gain_mixer_gain_bank.sv
// Double-buffered per-band gain storage: writes land in the pending bank, the
// commit strobe copies pending (including a same-edge write) into the active bank.
module eq_gain_bank
    import eq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [GAIN_W-1:0] wdata,
    input  logic              commit,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [GAIN_W-1:0] rd_gain
);

    logic [GAIN_W-1:0] pending_r      [NUM_BANDS];
    logic [GAIN_W-1:0] active_r       [NUM_BANDS];
    logic [GAIN_W-1:0] pending_next_s [NUM_BANDS];

    // Pending bank after this edge's write; out-of-range addresses match no entry.
    always_comb begin
        for (int k = 0; k < NUM_BANDS; k++) begin
            pending_next_s[k] = pending_r[k];
            if (we && (addr == IDX_W'(k))) begin
                pending_next_s[k] = wdata;
            end else begin
                pending_next_s[k] = pending_r[k];
            end
        end
    end

    // Indexed read of the active bank for the MAC.
    always_comb begin
        rd_gain = UNITY_GAIN;
        if (rd_idx < BAND_COUNT) begin
            rd_gain = active_r[rd_idx];
        end else begin
            rd_gain = UNITY_GAIN;
        end
    end

    // Pending and active bank registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
                pending_r[k] <= UNITY_GAIN;
                active_r[k]  <= UNITY_GAIN;
            end
        end else begin
            for (int k = 0; k < NUM_BANDS; k++) begin
                pending_r[k] <= pending_next_s[k];
                if (commit) begin
                    active_r[k] <= pending_next_s[k];
                end
            end
        end
    end

endmodule

// File: rtl/eq_band_gain_mixer.sv
// Ten-band gain mixer: captures the band samples on a strobe, accumulates
// band*gain with one shared MAC over ten cycles, then emits a rounded, saturated sample.
module eq_band_gain_mixer
    import eq_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [NUM_BANDS*DATA_W-1:0] band_in,
    input  logic                        gain_we,
    input  logic [3:0]                  gain_addr,
    input  logic [GAIN_W-1:0]           gain_data,
    output logic [DATA_W-1:0]           audio_out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;

    eq_state_t                  state_r;
    eq_state_t                  state_next_s;
    logic signed [DATA_W-1:0]   hold_r [NUM_BANDS];
    logic [IDX_W-1:0]           idx_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic [GAIN_W-1:0]          gain_s;
    logic signed [DATA_W-1:0]   band_s;
    logic signed [DATA_W+GAIN_W:0] product_s;
    logic signed [ACC_W-1:0]    rounded_s;
    logic                       capture_s;

    assign capture_s = (state_r == IDLE) && sample_valid;

    eq_gain_bank u_gain_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (gain_we),
        .addr    (gain_addr),
        .wdata   (gain_data),
        .commit  (capture_s),
        .rd_idx  (idx_r),
        .rd_gain (gain_s)
    );

    // Next-state logic for the capture / accumulate / output sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sample_valid) begin
                    state_next_s = ACC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACC: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = OUT;
                end else begin
                    state_next_s = ACC;
                end
            end
            OUT:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // MAC datapath: gain is zero-extended so Q2.10 values above 2.0 stay positive.
    always_comb begin
        band_s = '0;
        if (idx_r < BAND_COUNT) begin
            band_s = hold_r[idx_r];
        end else begin
            band_s = '0;
        end
        product_s = band_s * $signed({1'b0, gain_s});
        rounded_s = (acc_r + ROUND_BIAS) >>> GAIN_FRAC_BITS;
    end

    // State, holding register, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            acc_r     <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                hold_r[k] <= '0;
            end
        end else begin
            state_r   <= state_next_s;
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sample_valid) begin
                        for (int k = 0; k < NUM_BANDS; k++) begin
                            hold_r[k] <= band_in[k*DATA_W +: DATA_W];
                        end
                        acc_r <= '0;
                        idx_r <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACC: begin
                    acc_r <= acc_r + ACC_W'(product_s);
                    idx_r <= idx_r + 4'd1;
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                end
                OUT: begin
                    audio_out <= sat_data(rounded_s);
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_gain_mixer.sv
// Self-checking bench for eq_band_gain_mixer: a sample-level reference model
// checked every cycle, plus directed cases with hand-computed results.
module tb_eq_band_gain_mixer;
    import eq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_valid;
    logic [239:0] band_in;
    logic         gain_we;
    logic [3:0]   gain_addr;
    logic [11:0]  gain_data;
    logic [23:0]  audio_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    always #5 clk = ~clk;

    eq_band_gain_mixer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .band_in      (band_in),
        .gain_we      (gain_we),
        .gain_addr    (gain_addr),
        .gain_data    (gain_data),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Reference model state: gain banks, cycles left until output, pending result.
    int          m_pend [10];
    int          m_act  [10];
    int          m_cnt;
    logic [23:0] m_res;
    logic [23:0] m_out;
    logic        m_valid;
    logic        m_ov;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_mix(input logic [239:0] b, input int g [10]);
        longint s;
        s = 0;
        for (int k = 0; k < 10; k++) begin
            s += longint'($signed(b[k*24 +: 24])) * longint'(g[k]);
        end
        s = (s + 512) >>> 10;
        if (s > 64'sd8388607) return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
        return s[23:0];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int k = 0; k < 10; k++) begin
                m_pend[k] = 1024;
                m_act[k]  = 1024;
            end
            m_cnt = 0; m_out = 24'd0; m_valid = 1'b0; m_ov = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (gain_we && int'(gain_addr) < 10) m_pend[gain_addr] = int'(gain_data);
            if (m_cnt == 0) begin
                if (sample_valid) begin
                    m_act = m_pend;
                    m_res = ref_mix(band_in, m_act);
                    m_cnt = 11;
                end
            end else begin
                if (sample_valid) m_ov = 1'b1;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out   = m_res;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("audio_out", audio_out, m_out);
            check("out_valid", 24'(out_valid), 24'(m_valid));
            check("busy", 24'(busy), 24'(m_cnt != 0));
            check("overrun", 24'(overrun), 24'(m_ov));
        end
    end

    task automatic set_bands(input int b0, input int rest);
        int v;
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? b0 : rest;
            band_in[k*24 +: 24] = v[23:0];
        end
    endtask

    task automatic write_gain(input int a, input int g);
        gain_we = 1'b1; gain_addr = a[3:0]; gain_data = g[11:0];
        step();
        gain_we = 1'b0;
    endtask

    task automatic send(input int b0, input int rest);
        set_bands(b0, rest);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [23:0] exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (out_valid) got = 1'b1;
        end
        if (!got) check({name, "_timeout"}, 24'd0, 24'd1);
        else check(name, audio_out, exp);
    endtask

    function automatic logic [23:0] rand_band();
        int v;
        case ($urandom_range(0, 3))
            0: rand_band = 24'($urandom);
            1: begin v = int'($urandom_range(0, 4000)) - 2000; rand_band = v[23:0]; end
            2: rand_band = 24'h7FFFFF;
            default: rand_band = 24'h800000;
        endcase
    endfunction

    initial begin
        int extra;
        rst = 1'b1; sample_valid = 1'b0; gain_we = 1'b0;
        gain_addr = 4'd0; gain_data = 12'd0; band_in = '0;
        step();
        checking = 1'b1;
        step();
        rst = 1'b0;
        check("reset_audio", audio_out, 24'd0);
        check("reset_busy", 24'(busy), 24'd0);
        check("reset_overrun", 24'(overrun), 24'd0);

        send(1000, 0);  expect_out("unity_band0", 24'd1000);
        send(100, 100); expect_out("unity_all", 24'd1000);

        for (int k = 0; k < 10; k++) write_gain(k, 'hFFF);
        send(8388607, 8388607);   expect_out("sat_pos", 24'h7FFFFF);
        send(-8388608, -8388608); expect_out("sat_neg", 24'h800000);

        for (int k = 0; k < 10; k++) write_gain(k, 1024);
        write_gain(0, 'h200);
        send(3, 0);  expect_out("round_p3", 24'd2);
        send(-3, 0); expect_out("round_m3", 24'hFFFFFF);
        send(1, 0);  expect_out("round_p1", 24'd1);
        send(-1, 0); expect_out("round_m1", 24'd0);

        write_gain(0, 1024);
        send(500, 0); step(); step(); write_gain(0, 0);
        expect_out("dbuf_inflight", 24'd500);
        send(500, 0); expect_out("dbuf_next", 24'd0);
        set_bands(500, 0);
        gain_we = 1'b1; gain_addr = 4'd0; gain_data = 12'h800; sample_valid = 1'b1;
        step();
        gain_we = 1'b0; sample_valid = 1'b0;
        expect_out("dbuf_capture_write", 24'd1000);

        write_gain(0, 1024);
        send(700, 0); step(); step(); step(); step();
        send(9999, 0);
        expect_out("overrun_first", 24'd700);
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (out_valid) extra++;
        end
        check("overrun_single_pulse", 24'(extra), 24'd0);
        check("overrun_set", 24'(overrun), 24'd1);
        write_gain(12, 0);
        send(100, 100); expect_out("addr12_ignored", 24'd1000);
        check("overrun_sticky", 24'(overrun), 24'd1);

        write_gain(0, 0);
        send(1000, 0); step(); step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midacc_busy", 24'(busy), 24'd0);
        check("midacc_valid", 24'(out_valid), 24'd0);
        check("midacc_audio", audio_out, 24'd0);
        check("midacc_overrun", 24'(overrun), 24'd0);
        send(1000, 0); expect_out("post_reset_unity", 24'd1000);

        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            sample_valid = ($urandom_range(0, 3) == 0);
            gain_we      = ($urandom_range(0, 2) == 0);
            gain_addr    = 4'($urandom_range(0, 15));
            gain_data    = 12'($urandom);
            for (int k = 0; k < 10; k++) band_in[k*24 +: 24] = rand_band();
            step();
        end
        rst = 1'b0; sample_valid = 1'b0; gain_we = 1'b0;
        repeat (15) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eq_band_gain_mixer.md
Name: eq_band_gain_mixer

Overview:
Downstream stage of the ten-band FIR filter bank. It captures the ten 24-bit band outputs on a sample strobe and scales each band by a programmable gain. It sums the scaled bands with a single time-multiplexed multiply-accumulate and emits one saturated 24-bit equalised sample per strobe. Gains are written through a simple register-write port and double-buffered, so a gain change never affects a sample already being processed.

Parameters:
NUM_BANDS, 10, number of band inputs; index 0 = lowpass, 1..8 = 64 Hz to 16 kHz bands in order, 9 = highpass
DATA_W, 24, width of band samples and of the output (signed)
GAIN_W, 12, gain width; unsigned Q2.10 (0.0 to 3.999), unity = 0x400
ACC_W, 41, accumulator width (DATA_W+GAIN_W+1+clog2(NUM_BANDS))

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe: band_in is valid this cycle
band_in  in  NUM_BANDS*DATA_W  packed signed band samples; band k at bits [k*DATA_W +: DATA_W]
gain_we  in  1  gain write enable
gain_addr  in  4  band index for the write; values >= NUM_BANDS are ignored
gain_data  in  GAIN_W  gain value written to the pending bank
audio_out  out  DATA_W  signed equalised sample, held between updates
out_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high while a sample is being accumulated
overrun  out  1  sticky flag: a sample_valid was dropped while busy

Behaviour:
- Reset (rst=1 at a clock edge): audio_out=0, out_valid=0, busy=0, overrun=0, FSM=IDLE, accumulator=0. Both gain banks are set to 0x400 (unity) for every band. Reset has priority over all inputs and aborts an accumulation in progress; no out_valid is emitted for the aborted sample.
- Gain banks:
  - A write (gain_we=1, gain_addr<NUM_BANDS) updates the pending bank entry at that edge.
  - When a sample is captured, the whole pending bank is copied to the active bank on the same edge. A write on that same edge lands in pending and is included in the copy (write-through).
  - The MAC reads only the active bank.
- FSM states IDLE, ACC, OUT.
  - IDLE: sample_valid=1 at edge T captures band_in into a 10x24 holding register, commits gains, clears the accumulator and the band index, and moves to ACC; busy=1 from T.
  - ACC: at each edge T+1..T+10, acc += band[idx] * active_gain[idx] and idx increments. Product is signed 24 x zero-extended 13-bit = 37 bits, sign-extended to ACC_W. After idx=9 is accumulated (edge T+10), move to OUT.
  - OUT: at edge T+11, audio_out = sat24((acc + 512) >>> 10), i.e. round half toward +inf, then saturate. out_valid=1 for the cycle after T+11. busy=0. Return to IDLE.
  - Saturation: results above 0x7FFFFF clamp to 0x7FFFFF; results below -0x800000 clamp to 0x800000.
- Latency: 11 clocks from the sample_valid edge to the audio_out update. Throughput: one sample per 12 clocks minimum; a new sample_valid is accepted on the edge after the OUT edge.
- sample_valid while busy (states ACC or OUT) is ignored. The held data is untouched and overrun is set to 1, sticky until rst.
- sample_valid is not accepted on the OUT edge.
- gain_we is legal in any state and never stalls.

Decomposition:
- Shared package eq_pkg holds:
  - NUM_BANDS, DATA_W, GAIN_W, ACC_W
  - GAIN_FRAC_BITS=10 and UNITY_GAIN=12'h400
  - the FSM state enum (IDLE/ACC/OUT)
  - the saturate-to-DATA_W function
- One sub-module, eq_gain_bank: pending plus active gain register banks, write port, commit strobe, and an indexed read of the active gain.
- The MAC, holding register and FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-ACC -> next cycle busy=0, out_valid=0, audio_out=0, overrun=0; the first subsequent sample uses unity gains.
- Unity pass-through: default gains, band0=1000, others 0, sample_valid at T -> out_valid in the cycle after T+11, audio_out=1000. All ten bands=100 -> audio_out=1000.
- Saturation:
  - All bands=0x7FFFFF with all gains=0xFFF -> audio_out=0x7FFFFF.
  - All bands=0x800000 with gains=0xFFF -> audio_out=0x800000.
- Rounding, gain0=0x200 (0.5):
  - band0=3 -> 2
  - band0=-3 -> -1
  - band0=1 -> 1
  - band0=-1 -> 0
- Gain double-buffer:
  - Write gain0=0 at T+3 during an accumulation of band0=500 -> that output is 500.
  - The next sample with band0=500 -> 0.
  - Write gain0=0x800 on the capture edge itself -> that output is 1000.
- Overrun: sample_valid at T and again at T+5 -> only one out_valid, whose value comes from the T data; overrun=1 and stays 1 until rst. Addr 12 writes leave all gains unchanged.
